// File: rtl/hero_pkg.sv
// Shared definitions for the hero movement / wall collision logic.
// Provides the default wall count, the "no hit" index code, the width of the
// one-hot select bus shared with the collision mux, and the scan FSM states.
package hero_pkg;

  localparam int          N_WALLS_DEF = 12;
  localparam int          SEL_W_DEF   = 16;
  localparam logic [3:0]  NO_HIT      = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/wall_prio_enc.sv
// Lowest-set-bit encoder for the per-wall hit mask.
// Ports:
//   mask_i  - N_WALLS-bit hit mask, bit i set when wall i was hit
//   idx_o   - index of the lowest set bit, NO_HIT when the mask is zero
//   valid_o - high when at least one bit of the mask is set
module wall_prio_enc
  import hero_pkg::*;
#(
  parameter int N_WALLS = N_WALLS_DEF
) (
  input  logic [N_WALLS-1:0] mask_i,
  output logic [3:0]         idx_o,
  output logic               valid_o
);

  // Walk from the top slot down so the lowest set bit is the last one to
  // write the index; an empty mask leaves the NO_HIT default in place.
  always_comb begin
    idx_o   = NO_HIT;
    valid_o = 1'b0;
    for (int i = N_WALLS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wall_scan_ctrl.sv
// Per-frame sequencer for the hero's wall-collision mux.
// On each accepted frame tick it walks a one-hot select across the wall slots,
// one slot per clock, records the returned collision bit for each slot and
// then commits a hit mask, a lowest-hit index and a movement permit.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   frame_tick - one-cycle frame start pulse
//   coll       - collision bit from the mux for the current select
//   active     - one-hot wall select to the mux, zero when not scanning
//   busy       - scan in progress (SCAN or DONE)
//   done       - one-cycle pulse in the commit cycle
//   hit        - any wall hit in the last completed scan
//   hit_mask   - per-wall hit bits of the last completed scan
//   hit_idx    - lowest hit wall of the last scan, NO_HIT when none
//   move_ok    - hero may move: last scan clean and no scan running
//   overrun    - sticky flag, a frame tick arrived while busy
module wall_scan_ctrl
  import hero_pkg::*;
#(
  parameter int N_WALLS = N_WALLS_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               coll,
  output logic [SEL_W-1:0]   active,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [N_WALLS-1:0] hit_mask,
  output logic [3:0]         hit_idx,
  output logic               move_ok,
  output logic               overrun
);

  localparam logic [3:0] LAST_IDX = 4'(N_WALLS - 1);

  scan_state_t        stateQ, stateD;
  logic [3:0]         idxQ, idxD;
  logic [SEL_W-1:0]   activeQ, activeD;
  logic [N_WALLS-1:0] workQ, workD;
  logic [N_WALLS-1:0] hitMaskQ, hitMaskD;
  logic               hitQ, hitD;
  logic [3:0]         hitIdxQ, hitIdxD;
  logic               moveOkQ, moveOkD;
  logic               overrunQ, overrunD;
  logic [3:0]         encIdx;
  logic               encValid;

  wall_prio_enc #(
    .N_WALLS (N_WALLS)
  ) u_prio_enc (
    .mask_i  (workQ),
    .idx_o   (encIdx),
    .valid_o (encValid)
  );

  // State and result registers. Reset drops any partial scan and restores
  // the "no hit, no movement" results so the hero stays put until the first
  // full scan has been committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      idxQ     <= 4'd0;
      activeQ  <= '0;
      workQ    <= '0;
      hitMaskQ <= '0;
      hitQ     <= 1'b0;
      hitIdxQ  <= NO_HIT;
      moveOkQ  <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      idxQ     <= idxD;
      activeQ  <= activeD;
      workQ    <= workD;
      hitMaskQ <= hitMaskD;
      hitQ     <= hitD;
      hitIdxQ  <= hitIdxD;
      moveOkQ  <= moveOkD;
      overrunQ <= overrunD;
    end
  end

  // Next-state logic. IDLE arms the walk on a frame tick and withdraws the
  // movement permit; SCAN stores one collision bit per cycle and shifts the
  // select; DONE latches the results so they hold until the next commit.
  // Ticks that arrive while a scan is running never restart it.
  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    activeD  = activeQ;
    workD    = workQ;
    hitMaskD = hitMaskQ;
    hitD     = hitQ;
    hitIdxD  = hitIdxQ;
    moveOkD  = moveOkQ;
    overrunD = overrunQ | (frame_tick & (stateQ != IDLE));

    case (stateQ)
      IDLE: begin
        if (frame_tick) begin
          stateD  = SCAN;
          activeD = SEL_W'(1);
          idxD    = 4'd0;
          workD   = '0;
          moveOkD = 1'b0;
        end
      end
      SCAN: begin
        workD[idxQ] = coll;
        if (idxQ == LAST_IDX) begin
          stateD  = DONE;
          activeD = '0;
        end else begin
          activeD = activeQ << 1;
          idxD    = idxQ + 4'd1;
        end
      end
      DONE: begin
        stateD   = IDLE;
        hitMaskD = workQ;
        hitD     = encValid;
        hitIdxD  = encIdx;
        moveOkD  = ~encValid;
      end
      default: begin
        stateD  = IDLE;
        activeD = '0;
      end
    endcase
  end

  // Outputs. During the commit cycle the fresh results are shown straight
  // from the work mask so they are visible alongside the done pulse; the
  // registered copies take over from the following cycle. move_ok stays low
  // through DONE because it only comes from its register.
  always_comb begin
    active   = activeQ;
    busy     = (stateQ != IDLE);
    done     = (stateQ == DONE);
    hit_mask = done ? workQ    : hitMaskQ;
    hit      = done ? encValid : hitQ;
    hit_idx  = done ? encIdx   : hitIdxQ;
    move_ok  = moveOkQ;
    overrun  = overrunQ;
  end

endmodule

// File: tb/tb_wall_scan_ctrl.sv
// Self-checking bench for wall_scan_ctrl with a behavioural collision mux.
module tb_wall_scan_ctrl;
  import hero_pkg::*;

  localparam int NW = 12;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        coll;
  logic [15:0] active;
  logic        busy;
  logic        done;
  logic        hit;
  logic [11:0] hit_mask;
  logic [3:0]  hit_idx;
  logic        move_ok;
  logic        overrun;

  logic [11:0] wallSel;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [11:0] walls;
    logic [11:0] expMask;
    logic [3:0]  expIdx;
    logic        expHit;
    logic        expMoveOk;
  } vec_t;

  vec_t vecs[6];

  wall_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .coll       (coll),
    .active     (active),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_mask   (hit_mask),
    .hit_idx    (hit_idx),
    .move_ok    (move_ok),
    .overrun    (overrun)
  );

  // Collision mux model: reports a hit when the selected slot is a wall.
  assign coll = |(active[11:0] & wallSel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] refLowest(input logic [11:0] m);
    for (int i = 0; i < NW; i++) if (m[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " active"},   32'(active),   32'h0);
    checkOutput({tag, " busy"},     32'(busy),     32'h0);
    checkOutput({tag, " done"},     32'(done),     32'h0);
    checkOutput({tag, " hit"},      32'(hit),      32'h0);
    checkOutput({tag, " hit_mask"}, 32'(hit_mask), 32'h0);
    checkOutput({tag, " hit_idx"},  32'(hit_idx),  32'hF);
    checkOutput({tag, " move_ok"},  32'(move_ok),  32'h0);
    checkOutput({tag, " overrun"},  32'(overrun),  32'h0);
  endtask

  // Starts a scan at the current negedge (cycle T) and follows it to T+14,
  // leaving the bench at the negedge where the next tick may be issued.
  task automatic applyStimulus(input logic [11:0] walls, input logic [11:0] expMask,
                               input logic [3:0] expIdx, input logic expHit,
                               input logic expMoveOk);
    wallSel    = walls;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < NW; k++) begin
      checkOutput($sformatf("walk active k=%0d", k), 32'(active), 32'(16'h1 << k));
      if (k == 0 || k == NW - 1) begin
        checkOutput("walk busy", 32'(busy), 32'h1);
        checkOutput("walk move_ok", 32'(move_ok), 32'h0);
        checkOutput("walk done", 32'(done), 32'h0);
      end
      @(negedge clk);
    end
    checkOutput("T+13 done", 32'(done), 32'h1);
    checkOutput("T+13 active", 32'(active), 32'h0);
    checkOutput("T+13 busy", 32'(busy), 32'h1);
    checkOutput("T+13 move_ok", 32'(move_ok), 32'h0);
    checkOutput("T+13 hit_mask", 32'(hit_mask), 32'(expMask));
    checkOutput("T+13 hit_idx", 32'(hit_idx), 32'(expIdx));
    checkOutput("T+13 hit", 32'(hit), 32'(expHit));
    @(negedge clk);
    checkOutput("T+14 done", 32'(done), 32'h0);
    checkOutput("T+14 busy", 32'(busy), 32'h0);
    checkOutput("T+14 move_ok", 32'(move_ok), 32'(expMoveOk));
    checkOutput("T+14 hit_mask", 32'(hit_mask), 32'(expMask));
    checkOutput("T+14 hit_idx", 32'(hit_idx), 32'(expIdx));
  endtask

  initial begin
    int doneCount;
    logic [11:0] rnd;

    vecs[0] = '{12'h000, 12'h000, 4'hF, 1'b0, 1'b1};
    vecs[1] = '{12'h208, 12'h208, 4'd3, 1'b1, 1'b0};
    vecs[2] = '{12'h000, 12'h000, 4'hF, 1'b0, 1'b1};
    vecs[3] = '{12'h800, 12'h800, 4'd11, 1'b1, 1'b0};
    vecs[4] = '{12'h001, 12'h001, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{12'hFFF, 12'hFFF, 4'd0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    wallSel    = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("post-reset");

    $display("[TB] table-driven scans");
    foreach (vecs[i])
      applyStimulus(vecs[i].walls, vecs[i].expMask, vecs[i].expIdx,
                    vecs[i].expHit, vecs[i].expMoveOk);
    checkOutput("overrun after table", 32'(overrun), 32'h0);

    // Extra ticks inside SCAN (T+5) and DONE (T+13) must be ignored.
    $display("[TB] overrun sequence");
    wallSel    = 12'h010;
    frame_tick = 1'b1;
    doneCount  = 0;
    @(negedge clk);
    for (int c = 1; c <= 13; c++) begin
      frame_tick = (c == 5 || c == 13);
      if (c <= 12) checkOutput($sformatf("ovr active c=%0d", c), 32'(active),
                               32'(16'h1 << (c - 1)));
      if (done) doneCount++;
      @(negedge clk);
    end
    checkOutput("ovr done count", 32'(doneCount), 32'd1);
    checkOutput("ovr overrun", 32'(overrun), 32'h1);
    checkOutput("ovr busy T+14", 32'(busy), 32'h0);
    checkOutput("ovr hit_mask", 32'(hit_mask), 32'h010);
    checkOutput("ovr hit_idx", 32'(hit_idx), 32'd4);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checkOutput("ovr restart busy", 32'(busy), 32'h1);
    checkOutput("ovr restart active", 32'(active), 32'h1);
    repeat (12) @(negedge clk);
    checkOutput("ovr restart done", 32'(done), 32'h1);
    @(negedge clk);

    // Reset in the middle of a scan discards everything.
    $display("[TB] mid-scan reset");
    wallSel    = 12'h004;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("after midreset");
    @(negedge clk);
    checkOutput("after midreset hit_idx", 32'(hit_idx), 32'hF);
    checkOutput("after midreset done", 32'(done), 32'h0);

    // Back-to-back frames at the minimum period with random walls.
    $display("[TB] random back-to-back frames");
    for (int f = 0; f < 10; f++) begin
      rnd = 12'($urandom_range(0, 4095));
      applyStimulus(rnd, rnd, refLowest(rnd), |rnd, ~|rnd);
    end
    checkOutput("random overrun", 32'(overrun), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
